// File: rtl/grid_draw_scheduler_pkg.sv
// Shared constants, FSM state encoding and key codes for the grid draw scheduler.
// Also holds the wrap-around step helpers used for cursor moves.
package grid_pkg;

  localparam int GRID_N = 12;
  localparam int PITCH  = 33;
  localparam int X0     = 214;
  localparam int Y0     = 32;

  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_IDLE     = 3'd1,
    ST_ISSUE    = 3'd2,
    ST_WAIT_BOX = 3'd3,
    ST_WAIT_CUR = 3'd4,
    ST_GAP      = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    KEY_NONE   = 3'd0,
    KEY_TOGGLE = 3'd1,
    KEY_UP     = 3'd2,
    KEY_DOWN   = 3'd3,
    KEY_LEFT   = 3'd4,
    KEY_RIGHT  = 3'd5
  } key_t;

  function automatic logic [3:0] wrap_inc(input logic [3:0] v, input logic [3:0] last);
    return (v == last) ? 4'd0 : v + 4'd1;
  endfunction

  function automatic logic [3:0] wrap_dec(input logic [3:0] v, input logic [3:0] last);
    return (v == 4'd0) ? last : v - 4'd1;
  endfunction

endpackage

// File: rtl/grid_draw_scheduler_cell_to_pixel.sv
// Maps a grid cell (row, col) to the pixel origin of that cell on screen.
module cell_to_pixel #(
  parameter int PITCH = grid_pkg::PITCH,
  parameter int X0    = grid_pkg::X0,
  parameter int Y0    = grid_pkg::Y0
) (
  input  logic [3:0] row,
  input  logic [3:0] col,
  output logic [9:0] px,
  output logic [8:0] py
);

  assign px = 10'(X0) + 10'(PITCH) * {6'd0, col};
  assign py = 9'(Y0) + 9'(PITCH) * {5'd0, row};

endmodule

// File: rtl/grid_draw_scheduler.sv
// Cursor/bitmap editor that sequences draw transactions to a shared draw engine,
// runs a full-grid clear sweep and emits per-column note vectors on tempo ticks.
module grid_draw_scheduler
  import grid_pkg::*;
#(
  parameter int GRID_N = grid_pkg::GRID_N,
  parameter int PITCH  = grid_pkg::PITCH,
  parameter int X0     = grid_pkg::X0,
  parameter int Y0     = grid_pkg::Y0
) (
  input  logic              CLOCK_50,
  input  logic              nReset,
  input  logic              key_up,
  input  logic              key_down,
  input  logic              key_left,
  input  logic              key_right,
  input  logic              key_toggle,
  input  logic              clear_req,
  input  logic              step_tick,
  input  logic              drawing,
  output logic              draw_enable,
  output logic [9:0]        X,
  output logic [8:0]        Y,
  output logic [9:0]        OLD_X,
  output logic [8:0]        OLD_Y,
  output logic              cell_state,
  output logic              busy,
  output logic [3:0]        playhead,
  output logic [GRID_N-1:0] col_notes,
  output logic              note_strobe,
  output logic              drop_pulse
);

  localparam logic [3:0] LAST = 4'(GRID_N - 1);

  state_t state_r, state_nxt_s;
  logic drawing_d_r, rise_s, fall_s, init_fall_r, seen_rise_r, gap_cnt_r;
  logic [GRID_N-1:0][GRID_N-1:0] bitmap_r, bitmap_nxt_s;
  logic [3:0] cur_row_r, cur_col_r, cur_row_nxt_s, cur_col_nxt_s;
  logic [3:0] last_row_r, last_col_r, old_row_s, old_col_s;
  logic [3:0] swp_row_r, swp_col_r, swp_row_nxt_s, swp_col_nxt_s;
  logic swp_active_r, swp_last_s, pend_clear_r, pend_clear_nxt_s, pend_valid_r;
  key_t pend_key_r, fresh_key_s, apply_key_s;
  logic [4:0] keys_s;
  logic fresh_multi_s, key_go_s, use_slot_s, clr_go_s, swp_go_s, swp_end_s;
  logic slot_want_s, slot_load_s, slot_drop_s, load_s;
  logic [9:0] px_new_s, px_old_s, x_r, old_x_r;
  logic [8:0] py_new_s, py_old_s, y_r, old_y_r;
  logic cell_state_r, draw_enable_r, busy_r, note_strobe_r, drop_pulse_r, tick_d_r;
  logic [3:0] playhead_r;
  logic [GRID_N-1:0] col_notes_r;

  assign rise_s = drawing & ~drawing_d_r;
  assign fall_s = ~drawing & drawing_d_r;
  assign keys_s = {key_toggle, key_up, key_down, key_left, key_right};
  // More than one simultaneous key: all but the winner are dropped.
  assign fresh_multi_s = |(keys_s & (keys_s - 5'd1));
  assign swp_last_s = (swp_row_r == LAST) && (swp_col_r == LAST);

  // Fixed-priority pick of the winning fresh key pulse.
  always_comb begin
    fresh_key_s = KEY_NONE;
    if (key_toggle)     fresh_key_s = KEY_TOGGLE;
    else if (key_up)    fresh_key_s = KEY_UP;
    else if (key_down)  fresh_key_s = KEY_DOWN;
    else if (key_left)  fresh_key_s = KEY_LEFT;
    else if (key_right) fresh_key_s = KEY_RIGHT;
    else                fresh_key_s = KEY_NONE;
  end

  // Next-state logic and service strobes.
  always_comb begin
    state_nxt_s = state_r;
    key_go_s    = 1'b0;
    use_slot_s  = 1'b0;
    clr_go_s    = 1'b0;
    swp_go_s    = 1'b0;
    swp_end_s   = 1'b0;
    case (state_r)
      ST_INIT: begin
        if (fall_s && init_fall_r) state_nxt_s = ST_GAP;
        else                       state_nxt_s = state_r;
      end
      ST_IDLE: begin
        if (pend_clear_r) begin
          clr_go_s = 1'b1; state_nxt_s = ST_ISSUE;
        end else if (pend_valid_r) begin
          key_go_s = 1'b1; use_slot_s = 1'b1; state_nxt_s = ST_ISSUE;
        end else if (fresh_key_s != KEY_NONE) begin
          key_go_s = 1'b1; state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_ISSUE: state_nxt_s = ST_WAIT_BOX;
      ST_WAIT_BOX: begin
        if (fall_s && seen_rise_r) state_nxt_s = ST_WAIT_CUR;
        else                       state_nxt_s = state_r;
      end
      ST_WAIT_CUR: begin
        if (fall_s && seen_rise_r) state_nxt_s = ST_GAP;
        else                       state_nxt_s = state_r;
      end
      ST_GAP: begin
        if (!gap_cnt_r) begin
          state_nxt_s = state_r;
        end else if (swp_active_r && !swp_last_s) begin
          swp_go_s = 1'b1; state_nxt_s = ST_ISSUE;
        end else begin
          swp_end_s = 1'b1; state_nxt_s = ST_IDLE;
        end
      end
      default: state_nxt_s = ST_INIT;
    endcase
  end

  // Key application, pending slot, clear request and sweep cell datapath.
  always_comb begin
    apply_key_s   = use_slot_s ? pend_key_r : fresh_key_s;
    cur_row_nxt_s = cur_row_r;
    cur_col_nxt_s = cur_col_r;
    bitmap_nxt_s  = bitmap_r;
    if (key_go_s) begin
      case (apply_key_s)
        KEY_TOGGLE: bitmap_nxt_s[cur_row_r][cur_col_r] = ~bitmap_r[cur_row_r][cur_col_r];
        KEY_UP:     cur_row_nxt_s = wrap_dec(cur_row_r, LAST);
        KEY_DOWN:   cur_row_nxt_s = wrap_inc(cur_row_r, LAST);
        KEY_LEFT:   cur_col_nxt_s = wrap_dec(cur_col_r, LAST);
        KEY_RIGHT:  cur_col_nxt_s = wrap_inc(cur_col_r, LAST);
        default:    cur_row_nxt_s = cur_row_r;
      endcase
    end else begin
      bitmap_nxt_s = bitmap_r;
    end
    // A fresh key not consumed directly goes to the slot; a slot being consumed frees it.
    slot_want_s = (fresh_key_s != KEY_NONE) && !(key_go_s && !use_slot_s);
    slot_load_s = slot_want_s && (!pend_valid_r || use_slot_s);
    slot_drop_s = slot_want_s && pend_valid_r && !use_slot_s;
    if (clr_go_s)                                                  pend_clear_nxt_s = 1'b0;
    else if (clear_req && (state_r != ST_INIT) && !swp_active_r)   pend_clear_nxt_s = 1'b1;
    else                                                           pend_clear_nxt_s = pend_clear_r;
    if (swp_col_r == LAST) begin
      swp_row_nxt_s = swp_row_r + 4'd1; swp_col_nxt_s = 4'd0;
    end else begin
      swp_row_nxt_s = swp_row_r;        swp_col_nxt_s = swp_col_r + 4'd1;
    end
    if (clr_go_s) begin
      old_row_s = 4'd0;          old_col_s = 4'd0;
    end else if (swp_go_s) begin
      old_row_s = swp_row_nxt_s; old_col_s = swp_col_nxt_s;
    end else begin
      old_row_s = last_row_r;    old_col_s = last_col_r;
    end
    load_s = key_go_s | clr_go_s | swp_go_s;
  end

  cell_to_pixel #(.PITCH(PITCH), .X0(X0), .Y0(Y0)) u_new_px (
    .row(cur_row_nxt_s), .col(cur_col_nxt_s), .px(px_new_s), .py(py_new_s)
  );

  cell_to_pixel #(.PITCH(PITCH), .X0(X0), .Y0(Y0)) u_old_px (
    .row(old_row_s), .col(old_col_s), .px(px_old_s), .py(py_old_s)
  );

  // FSM state register.
  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) state_r <= ST_INIT;
    else         state_r <= state_nxt_s;
  end

  // Draw engine handshake tracking: edge history, startup fall count, rise seen, gap timer.
  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) begin
      drawing_d_r <= 1'b0;
      init_fall_r <= 1'b0;
      seen_rise_r <= 1'b0;
      gap_cnt_r   <= 1'b0;
    end else begin
      drawing_d_r <= drawing;
      init_fall_r <= (state_r == ST_INIT) ? (init_fall_r | fall_s) : 1'b0;
      if (state_nxt_s != state_r) seen_rise_r <= 1'b0;
      else if (rise_s)            seen_rise_r <= 1'b1;
      gap_cnt_r <= (state_r == ST_GAP) ? ~gap_cnt_r : 1'b0;
    end
  end

  // Editor state: bitmap, cursor, last drawn cell, pending slot, pending clear, sweep position.
  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) begin
      bitmap_r     <= '0;
      cur_row_r    <= 4'd0;
      cur_col_r    <= 4'd0;
      last_row_r   <= 4'd0;
      last_col_r   <= 4'd0;
      pend_valid_r <= 1'b0;
      pend_key_r   <= KEY_NONE;
      pend_clear_r <= 1'b0;
      swp_active_r <= 1'b0;
      swp_row_r    <= 4'd0;
      swp_col_r    <= 4'd0;
    end else begin
      pend_clear_r <= pend_clear_nxt_s;
      if (clr_go_s) begin
        bitmap_r     <= '0;
        swp_active_r <= 1'b1;
        swp_row_r    <= 4'd0;
        swp_col_r    <= 4'd0;
      end else if (swp_go_s) begin
        swp_row_r <= swp_row_nxt_s;
        swp_col_r <= swp_col_nxt_s;
      end else if (swp_end_s) begin
        swp_active_r <= 1'b0;
      end
      if (key_go_s) begin
        bitmap_r   <= bitmap_nxt_s;
        cur_row_r  <= cur_row_nxt_s;
        cur_col_r  <= cur_col_nxt_s;
        last_row_r <= cur_row_nxt_s;
        last_col_r <= cur_col_nxt_s;
      end
      if (slot_load_s) begin
        pend_valid_r <= 1'b1;
        pend_key_r   <= fresh_key_s;
      end else if (use_slot_s) begin
        pend_valid_r <= 1'b0;
      end
    end
  end

  // Registered transaction outputs, held until the next transaction is loaded.
  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) begin
      x_r           <= 10'(X0);
      y_r           <= 9'(Y0);
      old_x_r       <= 10'(X0);
      old_y_r       <= 9'(Y0);
      cell_state_r  <= 1'b0;
      draw_enable_r <= 1'b0;
      busy_r        <= 1'b1;
      drop_pulse_r  <= 1'b0;
    end else begin
      if (load_s) begin
        x_r          <= px_new_s;
        y_r          <= py_new_s;
        old_x_r      <= px_old_s;
        old_y_r      <= py_old_s;
        cell_state_r <= key_go_s ? bitmap_nxt_s[last_row_r][last_col_r] : 1'b0;
      end
      draw_enable_r <= (state_nxt_s == ST_ISSUE);
      busy_r        <= (state_nxt_s != ST_IDLE) | pend_clear_nxt_s;
      drop_pulse_r  <= fresh_multi_s | slot_drop_s;
    end
  end

  // Tempo playhead and note column capture, independent of the draw FSM.
  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) begin
      playhead_r    <= 4'd0;
      tick_d_r      <= 1'b0;
      note_strobe_r <= 1'b0;
      col_notes_r   <= '0;
    end else begin
      if (step_tick) playhead_r <= wrap_inc(playhead_r, LAST);
      tick_d_r      <= step_tick;
      note_strobe_r <= tick_d_r;
      if (tick_d_r) begin
        for (int r = 0; r < GRID_N; r++) col_notes_r[r] <= bitmap_r[r][playhead_r];
      end
    end
  end

  assign draw_enable = draw_enable_r;
  assign X           = x_r;
  assign Y           = y_r;
  assign OLD_X       = old_x_r;
  assign OLD_Y       = old_y_r;
  assign cell_state  = cell_state_r;
  assign busy        = busy_r;
  assign playhead    = playhead_r;
  assign col_notes   = col_notes_r;
  assign note_strobe = note_strobe_r;
  assign drop_pulse  = drop_pulse_r;

endmodule

// File: tb/tb_grid_draw_scheduler.sv
// Directed self-checking bench for grid_draw_scheduler with a scripted draw-engine handshake.
module tb_grid_draw_scheduler;

  logic CLOCK_50 = 1'b0;
  logic nReset = 1'b0;
  logic key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0, key_toggle = 1'b0;
  logic clear_req = 1'b0, step_tick = 1'b0, drawing = 1'b0;
  logic draw_enable, cell_state, busy, note_strobe, drop_pulse;
  logic [9:0] X, OLD_X;
  logic [8:0] Y, OLD_Y;
  logic [3:0] playhead;
  logic [11:0] col_notes;

  int errors = 0;
  int checks = 0;
  int de_cnt = 0;
  int drop_cnt = 0;

  localparam logic [4:0] K_T = 5'b10000, K_U = 5'b01000, K_D = 5'b00100, K_L = 5'b00010, K_R = 5'b00001;

  grid_draw_scheduler dut (
    .CLOCK_50(CLOCK_50), .nReset(nReset),
    .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
    .key_toggle(key_toggle), .clear_req(clear_req), .step_tick(step_tick), .drawing(drawing),
    .draw_enable(draw_enable), .X(X), .Y(Y), .OLD_X(OLD_X), .OLD_Y(OLD_Y),
    .cell_state(cell_state), .busy(busy), .playhead(playhead), .col_notes(col_notes),
    .note_strobe(note_strobe), .drop_pulse(drop_pulse)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(negedge CLOCK_50) begin
    if (draw_enable === 1'b1) de_cnt <= de_cnt + 1;
    if (drop_pulse === 1'b1) drop_cnt <= drop_cnt + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_keys(input logic [4:0] k);
    @(negedge CLOCK_50);
    {key_toggle, key_up, key_down, key_left, key_right} = k;
    @(negedge CLOCK_50);
    {key_toggle, key_up, key_down, key_left, key_right} = 5'b00000;
  endtask

  task automatic drawing_pulse;
    @(negedge CLOCK_50); drawing = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    drawing = 1'b0;
    @(negedge CLOCK_50);
  endtask

  task automatic finish_txn;
    drawing_pulse;
    drawing_pulse;
  endtask

  task automatic wait_de(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (draw_enable === 1'b1) begin ok = 1'b1; break; end
      @(negedge CLOCK_50);
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (busy === 1'b0) begin ok = 1'b1; break; end
      @(negedge CLOCK_50);
    end
  endtask

  // Navigation move whose coordinates are not the point of the test.
  task automatic nav(input logic [4:0] k);
    bit ok;
    pulse_keys(k);
    wait_de(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL nav_draw_enable: got none expected pulse for key %b", k); end
    finish_txn;
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL nav_idle: busy stuck expected 0"); end
  endtask

  task automatic test_reset;
    nReset = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    checks++;
    if ({X, Y, OLD_X, OLD_Y, cell_state} !== {10'd214, 9'd32, 10'd214, 9'd32, 1'b0}) begin
      errors++; $display("FAIL reset_coords: got %h expected %h", {X, Y, OLD_X, OLD_Y, cell_state}, {10'd214, 9'd32, 10'd214, 9'd32, 1'b0});
    end
    checks++;
    if ({draw_enable, note_strobe, drop_pulse, busy, playhead, col_notes} !== {1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 12'd0}) begin
      errors++; $display("FAIL reset_flags: got %h expected %h", {draw_enable, note_strobe, drop_pulse, busy, playhead, col_notes}, {1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 12'd0});
    end
    nReset = 1'b1;
  endtask

  task automatic test_startup;
    bit ok;
    drawing_pulse;
    repeat (6) @(negedge CLOCK_50);
    checks++;
    if ({busy, de_cnt} !== {1'b1, 32'd0}) begin
      errors++; $display("FAIL init_one_fall: got busy=%b de=%0d expected busy=1 de=0", busy, de_cnt);
    end
    drawing_pulse;
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL init_to_idle: busy stuck expected 0"); end
    pulse_keys(K_R);
    wait_de(ok);
    checks++;
    if (!ok || {X, Y, OLD_X, OLD_Y, cell_state} !== {10'd247, 9'd32, 10'd214, 9'd32, 1'b0}) begin
      errors++; $display("FAIL startup_right: got %0d,%0d old %0d,%0d cs %b expected 247,32 old 214,32 cs 0", X, Y, OLD_X, OLD_Y, cell_state);
    end
    finish_txn;
    wait_idle(ok);
  endtask

  task automatic test_wrap;
    bit ok;
    nav(K_L);
    pulse_keys(K_L);
    wait_de(ok);
    checks++;
    if (!ok || {X, Y, OLD_X, OLD_Y} !== {10'd577, 9'd32, 10'd214, 9'd32}) begin
      errors++; $display("FAIL wrap_left: got %0d,%0d old %0d,%0d expected 577,32 old 214,32", X, Y, OLD_X, OLD_Y);
    end
    finish_txn;
    wait_idle(ok);
    pulse_keys(K_R);
    wait_de(ok);
    checks++;
    if (!ok || {X, OLD_X} !== {10'd214, 10'd577}) begin
      errors++; $display("FAIL wrap_right: got X=%0d OLD_X=%0d expected 214,577", X, OLD_X);
    end
    finish_txn;
    wait_idle(ok);
  endtask

  task automatic test_toggle_move;
    bit ok;
    nav(K_D); nav(K_D); nav(K_R); nav(K_R); nav(K_R);
    pulse_keys(K_T);
    wait_de(ok);
    checks++;
    if (!ok || {X, Y, OLD_X, OLD_Y, cell_state} !== {10'd313, 9'd98, 10'd313, 9'd98, 1'b1}) begin
      errors++; $display("FAIL toggle: got %0d,%0d old %0d,%0d cs %b expected 313,98 old 313,98 cs 1", X, Y, OLD_X, OLD_Y, cell_state);
    end
    finish_txn;
    wait_idle(ok);
    pulse_keys(K_D);
    wait_de(ok);
    checks++;
    if (!ok || {X, Y, OLD_X, OLD_Y, cell_state} !== {10'd313, 9'd131, 10'd313, 9'd98, 1'b1}) begin
      errors++; $display("FAIL toggle_then_down: got %0d,%0d old %0d,%0d cs %b expected 313,131 old 313,98 cs 1", X, Y, OLD_X, OLD_Y, cell_state);
    end
    finish_txn;
    wait_idle(ok);
  endtask

  task automatic test_busy_drop;
    bit ok;
    int de0, dr0;
    dr0 = drop_cnt;
    pulse_keys(K_R);
    wait_de(ok);
    de0 = de_cnt + 1;
    pulse_keys(K_U);
    pulse_keys(K_D);
    finish_txn;
    wait_de(ok);
    checks++;
    if (!ok || {X, Y, OLD_X, OLD_Y} !== {10'd346, 9'd98, 10'd346, 9'd131}) begin
      errors++; $display("FAIL pending_up: got %0d,%0d old %0d,%0d expected 346,98 old 346,131", X, Y, OLD_X, OLD_Y);
    end
    finish_txn;
    wait_idle(ok);
    repeat (10) @(negedge CLOCK_50);
    checks++;
    if (de_cnt !== de0 + 1) begin
      errors++; $display("FAIL busy_txn_count: got %0d expected %0d", de_cnt, de0 + 1);
    end
    checks++;
    if (drop_cnt !== dr0 + 1) begin
      errors++; $display("FAIL busy_drop_count: got %0d expected %0d", drop_cnt, dr0 + 1);
    end
  endtask

  task automatic test_simultaneous;
    bit ok;
    int dr0;
    dr0 = drop_cnt;
    pulse_keys(K_L | K_R);
    wait_de(ok);
    checks++;
    if (!ok || {X, Y, OLD_X, OLD_Y} !== {10'd313, 9'd98, 10'd346, 9'd98}) begin
      errors++; $display("FAIL simul_left_wins: got %0d,%0d old %0d,%0d expected 313,98 old 346,98", X, Y, OLD_X, OLD_Y);
    end
    finish_txn;
    wait_idle(ok);
    repeat (4) @(negedge CLOCK_50);
    checks++;
    if (drop_cnt !== dr0 + 1) begin
      errors++; $display("FAIL simul_drop_count: got %0d expected %0d", drop_cnt, dr0 + 1);
    end
  endtask

  task automatic tick_check(input logic [3:0] eph, input logic [11:0] enotes);
    @(negedge CLOCK_50); step_tick = 1'b1;
    @(negedge CLOCK_50); step_tick = 1'b0;
    @(negedge CLOCK_50);
    checks++;
    if ({note_strobe, playhead, col_notes} !== {1'b1, eph, enotes}) begin
      errors++; $display("FAIL tick_notes: got strobe=%b ph=%0d notes=%h expected 1,%0d,%h", note_strobe, playhead, col_notes, eph, enotes);
    end
    @(negedge CLOCK_50);
    checks++;
    if (note_strobe !== 1'b0) begin
      errors++; $display("FAIL tick_strobe_width: got %b expected 0", note_strobe);
    end
  endtask

  task automatic test_notes;
    nav(K_R); nav(K_T); nav(K_R); nav(K_T); nav(K_D); nav(K_T); nav(K_D); nav(K_T);
    tick_check(4'd1, 12'h000);
    tick_check(4'd2, 12'h000);
    tick_check(4'd3, 12'h004);
    tick_check(4'd4, 12'h004);
    tick_check(4'd5, 12'h01C);
  endtask

  task automatic test_clear;
    bit ok;
    int de0;
    logic [9:0] eox;
    logic [8:0] eoy;
    de0 = de_cnt;
    @(negedge CLOCK_50); clear_req = 1'b1;
    @(negedge CLOCK_50); clear_req = 1'b0;
    for (int i = 0; i < 144; i++) begin
      wait_de(ok);
      eox = 10'(214 + 33 * (i % 12));
      eoy = 9'(32 + 33 * (i / 12));
      checks++;
      if (!ok || {X, Y, OLD_X, OLD_Y, cell_state} !== {10'd379, 9'd164, eox, eoy, 1'b0}) begin
        errors++; $display("FAIL sweep_cell_%0d: got %0d,%0d old %0d,%0d cs %b expected 379,164 old %0d,%0d cs 0", i, X, Y, OLD_X, OLD_Y, cell_state, eox, eoy);
        break;
      end
      if (i == 10) begin
        @(negedge CLOCK_50); clear_req = 1'b1;
        @(negedge CLOCK_50); clear_req = 1'b0;
      end
      finish_txn;
      if (i == 70) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL sweep_busy: got %b expected 1", busy); end
      end
    end
    wait_idle(ok);
    repeat (10) @(negedge CLOCK_50);
    checks++;
    if (de_cnt !== de0 + 144 || busy !== 1'b0) begin
      errors++; $display("FAIL sweep_count: got %0d busy=%b expected %0d busy=0", de_cnt - de0, busy, 144);
    end
    for (int i = 0; i < 11; i++) begin
      @(negedge CLOCK_50); step_tick = 1'b1;
      @(negedge CLOCK_50); step_tick = 1'b0;
    end
    tick_check(4'd5, 12'h000);
  endtask

  task automatic test_reset_mid_sweep;
    bit ok;
    int de0;
    @(negedge CLOCK_50); clear_req = 1'b1;
    @(negedge CLOCK_50); clear_req = 1'b0;
    for (int i = 0; i < 50; i++) begin
      wait_de(ok);
      if (!ok) break;
      finish_txn;
    end
    wait_de(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL sweep51_start: got none expected draw_enable"); end
    @(negedge CLOCK_50); drawing = 1'b1;
    @(negedge CLOCK_50); nReset = 1'b0;
    @(negedge CLOCK_50); drawing = 1'b0;
    checks++;
    if ({X, Y, OLD_X, OLD_Y, cell_state, draw_enable, busy, playhead} !== {10'd214, 9'd32, 10'd214, 9'd32, 1'b0, 1'b0, 1'b1, 4'd0}) begin
      errors++; $display("FAIL midsweep_reset_vals: got %h expected %h", {X, Y, OLD_X, OLD_Y, cell_state, draw_enable, busy, playhead}, {10'd214, 9'd32, 10'd214, 9'd32, 1'b0, 1'b0, 1'b1, 4'd0});
    end
    @(negedge CLOCK_50); nReset = 1'b1;
    de0 = de_cnt;
    repeat (30) @(negedge CLOCK_50);
    drawing_pulse;
    repeat (10) @(negedge CLOCK_50);
    checks++;
    if ({busy, de_cnt} !== {1'b1, de0}) begin
      errors++; $display("FAIL midsweep_init_hold: got busy=%b de=%0d expected busy=1 de=%0d", busy, de_cnt, de0);
    end
    drawing_pulse;
    wait_idle(ok);
    pulse_keys(K_R);
    wait_de(ok);
    checks++;
    if (!ok || {X, Y, OLD_X, OLD_Y, cell_state} !== {10'd247, 9'd32, 10'd214, 9'd32, 1'b0}) begin
      errors++; $display("FAIL post_reset_right: got %0d,%0d old %0d,%0d cs %b expected 247,32 old 214,32 cs 0", X, Y, OLD_X, OLD_Y, cell_state);
    end
    finish_txn;
  endtask

  initial begin
    test_reset;
    test_startup;
    test_wrap;
    test_toggle_move;
    test_busy_drop;
    test_simultaneous;
    test_notes;
    test_clear;
    test_reset_mid_sweep;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
